ofs_plat_hssi_fiu_if_emulator: RTL and testbench

- Simulation/emulation model of the FIU end of the HSSI PR interface. It consumes the AFU-driven a2f resets, init and loopback controls, and drives f2a calibration, lock, ready and init-done status.
- It provides per-lane serial-loopback RX data, so AFU HSSI logic can be brought up and tested without a real transceiver.

---
 rtl/ofs_plat_hssi_fiu_if_emulator.sv | 203 ++++++++++++++++++++
 tb/tb_ofs_plat_hssi_fiu_if_emulator.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_hssi_fiu_if_emulator.sv
// Emulated FIU end of the HSSI PR interface: init/calibration/lock sequencing plus per-lane serial loopback.
// Status outputs are registered from FSM state; loopback data is LPBK_LATENCY registers deep, gated by READY and lane enable.
module ofs_plat_hssi_fiu_if_emulator #(
  parameter int NUM_LANES    = 4,
  parameter int LANE_DATA_W  = 64,
  parameter int LANE_CTL_W   = 8,
  parameter int CAL_CYCLES   = 32,
  parameter int LOCK_CYCLES  = 16,
  parameter int LPBK_LATENCY = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_LANES-1:0]              a2f_tx_analogreset,
  input  logic [NUM_LANES-1:0]              a2f_rx_analogreset,
  input  logic [NUM_LANES-1:0]              a2f_tx_digitalreset,
  input  logic [NUM_LANES-1:0]              a2f_rx_digitalreset,
  input  logic                              a2f_init_start,
  input  logic [NUM_LANES-1:0]              a2f_rx_seriallpbken,
  input  logic [NUM_LANES*LANE_DATA_W-1:0]  a2f_tx_parallel_data,
  input  logic [NUM_LANES*LANE_CTL_W-1:0]   a2f_tx_control,
  input  logic [NUM_LANES-1:0]              a2f_tx_enh_data_valid,
  output logic [NUM_LANES-1:0]              f2a_tx_cal_busy,
  output logic [NUM_LANES-1:0]              f2a_rx_cal_busy,
  output logic [NUM_LANES-1:0]              f2a_rx_is_lockedtoref,
  output logic [NUM_LANES-1:0]              f2a_rx_is_lockedtodata,
  output logic [NUM_LANES-1:0]              f2a_tx_ready,
  output logic [NUM_LANES-1:0]              f2a_rx_ready,
  output logic                              f2a_init_done,
  output logic [NUM_LANES*LANE_DATA_W-1:0]  f2a_rx_parallel_data,
  output logic [NUM_LANES*LANE_CTL_W-1:0]   f2a_rx_control,
  output logic [NUM_LANES-1:0]              f2a_rx_enh_data_valid
);

  localparam int DW      = NUM_LANES * LANE_DATA_W;
  localparam int CW      = NUM_LANES * LANE_CTL_W;
  localparam int CNT_MAX = (CAL_CYCLES > LOCK_CYCLES) ? CAL_CYCLES : LOCK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAL,
    S_WAIT_DRST,
    S_LOCK,
    S_READY
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_any_arst;
  logic             w_any_drst;
  logic             w_ready;
  logic             w_locked;

  assign w_any_arst = (|a2f_tx_analogreset) | (|a2f_rx_analogreset);
  assign w_any_drst = (|a2f_tx_digitalreset) | (|a2f_rx_digitalreset);
  assign w_ready    = (r_state == S_READY);
  assign w_locked   = (r_state == S_WAIT_DRST) || (r_state == S_LOCK) || (r_state == S_READY);

  // Status is a function of the state held before this edge, so transitions show one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state                <= S_IDLE;
      r_cnt                  <= '0;
      f2a_tx_cal_busy        <= '0;
      f2a_rx_cal_busy        <= '0;
      f2a_rx_is_lockedtoref  <= '0;
      f2a_rx_is_lockedtodata <= '0;
      f2a_tx_ready           <= '0;
      f2a_rx_ready           <= '0;
      f2a_init_done          <= 1'b0;
    end else begin
      f2a_tx_cal_busy        <= {NUM_LANES{r_state == S_CAL}};
      f2a_rx_cal_busy        <= {NUM_LANES{r_state == S_CAL}};
      f2a_rx_is_lockedtoref  <= {NUM_LANES{w_locked}};
      f2a_rx_is_lockedtodata <= {NUM_LANES{w_ready}};
      f2a_tx_ready           <= {NUM_LANES{w_ready}};
      f2a_rx_ready           <= {NUM_LANES{w_ready}};
      f2a_init_done          <= w_ready;

      if (a2f_init_start) begin
        r_state <= S_CAL;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_cnt <= '0;
          S_CAL: begin
            if (w_any_arst) begin
              r_cnt <= '0;
            end else if (r_cnt == CAL_LAST) begin
              r_state <= S_WAIT_DRST;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_WAIT_DRST: begin
            r_cnt <= '0;
            if (w_any_arst) begin
              r_state <= S_CAL;
            end else if (!w_any_drst) begin
              r_state <= S_LOCK;
            end
          end
          S_LOCK: begin
            if (w_any_arst) begin
              r_state <= S_CAL;
              r_cnt   <= '0;
            end else if (w_any_drst) begin
              r_state <= S_WAIT_DRST;
              r_cnt   <= '0;
            end else if (r_cnt == LOCK_LAST) begin
              r_state <= S_READY;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_READY: begin
            r_cnt <= '0;
            if (w_any_arst) begin
              r_state <= S_CAL;
            end else if (w_any_drst) begin
              r_state <= S_WAIT_DRST;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  logic [DW-1:0]        w_pre_dat;
  logic [CW-1:0]        w_pre_ctl;
  logic [NUM_LANES-1:0] w_pre_vld;

  // The final output register is the last pipeline stage; the stages before it never stall.
  if (LPBK_LATENCY > 1) begin : g_pipe
    localparam int NS = LPBK_LATENCY - 1;
    logic [DW-1:0]        r_dat [NS];
    logic [CW-1:0]        r_ctl [NS];
    logic [NUM_LANES-1:0] r_vld [NS];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < NS; s++) begin
          r_dat[s] <= '0;
          r_ctl[s] <= '0;
          r_vld[s] <= '0;
        end
      end else begin
        r_dat[0] <= a2f_tx_parallel_data;
        r_ctl[0] <= a2f_tx_control;
        r_vld[0] <= a2f_tx_enh_data_valid;
        for (int s = 1; s < NS; s++) begin
          r_dat[s] <= r_dat[s-1];
          r_ctl[s] <= r_ctl[s-1];
          r_vld[s] <= r_vld[s-1];
        end
      end
    end

    assign w_pre_dat = r_dat[NS-1];
    assign w_pre_ctl = r_ctl[NS-1];
    assign w_pre_vld = r_vld[NS-1];
  end else begin : g_nopipe
    assign w_pre_dat = a2f_tx_parallel_data;
    assign w_pre_ctl = a2f_tx_control;
    assign w_pre_vld = a2f_tx_enh_data_valid;
  end

  logic [NUM_LANES-1:0] w_lane_on;
  logic [DW-1:0]        w_dat_mask;
  logic [CW-1:0]        w_ctl_mask;

  assign w_lane_on = {NUM_LANES{w_ready}} & a2f_rx_seriallpbken;

  always_comb begin
    w_dat_mask = '0;
    w_ctl_mask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_dat_mask[i*LANE_DATA_W +: LANE_DATA_W] = {LANE_DATA_W{w_lane_on[i]}};
      w_ctl_mask[i*LANE_CTL_W +: LANE_CTL_W]   = {LANE_CTL_W{w_lane_on[i]}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f2a_rx_parallel_data  <= '0;
      f2a_rx_control        <= '0;
      f2a_rx_enh_data_valid <= '0;
    end else begin
      f2a_rx_parallel_data  <= w_pre_dat & w_dat_mask;
      f2a_rx_control        <= w_pre_ctl & w_ctl_mask;
      f2a_rx_enh_data_valid <= w_pre_vld & w_lane_on;
    end
  end

endmodule

// File: tb/tb_ofs_plat_hssi_fiu_if_emulator.sv
// Bench for the HSSI FIU emulator: init sequencing, reset priorities and loopback against a queue-based model.
module tb_ofs_plat_hssi_fiu_if_emulator;

  localparam int NL   = 4;
  localparam int DW   = 64;
  localparam int CW   = 8;
  localparam int CAL  = 32;
  localparam int LOCK = 16;
  localparam int LAT  = 3;
  localparam int TDW  = NL * DW;
  localparam int TCW  = NL * CW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NL-1:0]  tx_arst = '0, rx_arst = '0, tx_drst = '0, rx_drst = '0;
  logic           init_start = 1'b0;
  logic [NL-1:0]  lpbken = '0;
  logic [TDW-1:0] tx_dat = '0;
  logic [TCW-1:0] tx_ctl = '0;
  logic [NL-1:0]  tx_vld = '0;

  logic [NL-1:0]  tx_cal_busy, rx_cal_busy, lref, ldata, tx_rdy, rx_rdy, rx_vld;
  logic           init_done;
  logic [TDW-1:0] rx_dat;
  logic [TCW-1:0] rx_ctl;

  int checks = 0;
  int errors = 0;

  logic [TDW-1:0] q_dat [$];
  logic [TCW-1:0] q_ctl [$];
  logic [NL-1:0]  q_vld [$];

  ofs_plat_hssi_fiu_if_emulator #(
    .NUM_LANES(NL), .LANE_DATA_W(DW), .LANE_CTL_W(CW),
    .CAL_CYCLES(CAL), .LOCK_CYCLES(LOCK), .LPBK_LATENCY(LAT)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .a2f_tx_analogreset    (tx_arst),
    .a2f_rx_analogreset    (rx_arst),
    .a2f_tx_digitalreset   (tx_drst),
    .a2f_rx_digitalreset   (rx_drst),
    .a2f_init_start        (init_start),
    .a2f_rx_seriallpbken   (lpbken),
    .a2f_tx_parallel_data  (tx_dat),
    .a2f_tx_control        (tx_ctl),
    .a2f_tx_enh_data_valid (tx_vld),
    .f2a_tx_cal_busy       (tx_cal_busy),
    .f2a_rx_cal_busy       (rx_cal_busy),
    .f2a_rx_is_lockedtoref (lref),
    .f2a_rx_is_lockedtodata(ldata),
    .f2a_tx_ready          (tx_rdy),
    .f2a_rx_ready          (rx_rdy),
    .f2a_init_done         (init_done),
    .f2a_rx_parallel_data  (rx_dat),
    .f2a_rx_control        (rx_ctl),
    .f2a_rx_enh_data_valid (rx_vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TDW-1:0] rand_dat();
    logic [TDW-1:0] r;
    for (int i = 0; i < TDW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Expected global phase k ticks after the init_start sampling tick (k=0), all resets low.
  // 0=CAL, 1=WAIT_DRST, 2=LOCK, 3=READY, as seen on the registered status outputs.
  function automatic int phase_of(int k);
    if (k <= CAL) return 0;
    if (k == CAL + 1) return 1;
    if (k <= CAL + 1 + LOCK) return 2;
    return 3;
  endfunction

  task automatic wait_init_done(input int budget, output int n);
    n = 0;
    while (init_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done_timeout got %b after %0d cycles required 1", init_done, n);
    end
  endtask

  task automatic model_clear();
    q_dat.delete(); q_ctl.delete(); q_vld.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      q_dat.push_back('0); q_ctl.push_back('0); q_vld.push_back('0);
    end
  endtask

  task automatic lpbk_cycle(input logic [TDW-1:0] d, input logic [TCW-1:0] c,
                            input logic [NL-1:0] v, input logic [NL-1:0] en);
    logic [TDW-1:0] ed;
    logic [TCW-1:0] ec;
    logic [NL-1:0]  ev;
    tx_dat = d; tx_ctl = c; tx_vld = v; lpbken = en;
    q_dat.push_back(d); q_ctl.push_back(c); q_vld.push_back(v);
    tick();
    ed = q_dat[q_dat.size() - LAT];
    ec = q_ctl[q_ctl.size() - LAT];
    ev = q_vld[q_vld.size() - LAT];
    for (int i = 0; i < NL; i++) begin
      if (!en[i]) begin
        ed[i*DW +: DW] = '0;
        ec[i*CW +: CW] = '0;
        ev[i] = 1'b0;
      end
    end
    if (q_dat.size() > LAT) begin
      void'(q_dat.pop_front()); void'(q_ctl.pop_front()); void'(q_vld.pop_front());
    end
    checks++;
    if (rx_dat !== ed) begin
      errors++;
      $display("FAIL lpbk_dat got %h required %h", rx_dat, ed);
    end
    checks++;
    if (rx_ctl !== ec || rx_vld !== ev) begin
      errors++;
      $display("FAIL lpbk_ctl_vld got %h/%b required %h/%b", rx_ctl, rx_vld, ec, ev);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({tx_cal_busy, rx_cal_busy, lref, ldata, tx_rdy, rx_rdy, init_done} !== '0) begin
      errors++;
      $display("FAIL reset_status got %b required 0",
               {tx_cal_busy, rx_cal_busy, lref, ldata, tx_rdy, rx_rdy, init_done});
    end
    checks++;
    if (rx_dat !== '0 || rx_ctl !== '0 || rx_vld !== '0) begin
      errors++;
      $display("FAIL reset_rx got %h/%h/%b required 0", rx_dat, rx_ctl, rx_vld);
    end
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({tx_cal_busy, lref, init_done} !== '0) begin
      errors++;
      $display("FAIL idle_status got %b required 0", {tx_cal_busy, lref, init_done});
    end
  endtask

  task automatic test_init();
    int first_done;
    int ph;
    first_done = -1;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int k = 1; k <= CAL + LOCK + 4; k++) begin
      tx_dat = rand_dat(); tx_ctl = $urandom(); tx_vld = NL'($urandom()); lpbken = '1;
      tick();
      ph = phase_of(k);
      if (init_done === 1'b1 && first_done < 0) first_done = k;
      checks++;
      if (tx_cal_busy !== {NL{ph == 0}} || rx_cal_busy !== {NL{ph == 0}}) begin
        errors++;
        $display("FAIL init_cal_busy k=%0d got %h/%h required %h", k, tx_cal_busy, rx_cal_busy, {NL{ph == 0}});
      end
      checks++;
      if (lref !== {NL{ph >= 1}} || ldata !== {NL{ph == 3}}) begin
        errors++;
        $display("FAIL init_lock k=%0d got %h/%h required %h/%h", k, lref, ldata, {NL{ph >= 1}}, {NL{ph == 3}});
      end
      checks++;
      if (tx_rdy !== {NL{ph == 3}} || rx_rdy !== {NL{ph == 3}} || init_done !== (ph == 3)) begin
        errors++;
        $display("FAIL init_ready k=%0d got %h/%h/%b required phase %0d", k, tx_rdy, rx_rdy, init_done, ph);
      end
      if (ph != 3) begin
        checks++;
        if (rx_dat !== '0 || rx_vld !== '0) begin
          errors++;
          $display("FAIL init_rx_gated k=%0d got %h/%b required 0", k, rx_dat, rx_vld);
        end
      end
    end
    checks++;
    if (first_done != CAL + LOCK + 2) begin
      errors++;
      $display("FAIL init_done_latency got %0d required %0d", first_done, CAL + LOCK + 2);
    end
    tx_dat = '0; tx_ctl = '0; tx_vld = '0; lpbken = '0;
  endtask

  task automatic test_analog_hold();
    int n;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (5) tick();
    rx_arst[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (tx_cal_busy !== '1) begin
        errors++;
        $display("FAIL arst_hold_busy k=%0d got %h required f", k, tx_cal_busy);
      end
    end
    rx_arst[2] = 1'b0;
    n = 0;
    tick();
    while (tx_cal_busy === '1 && n < 4 * CAL) begin
      n++;
      tick();
    end
    checks++;
    if (n != CAL) begin
      errors++;
      $display("FAIL arst_release_busy_len got %0d required %0d", n, CAL);
    end
    checks++;
    if (lref !== '1 || rx_cal_busy !== '0) begin
      errors++;
      $display("FAIL arst_wait_drst got %h/%h required f/0", lref, rx_cal_busy);
    end
    wait_init_done(LOCK + 10, n);
  endtask

  task automatic test_loopback();
    repeat (LAT) lpbk_cycle_zero();
    model_clear();
    lpbk_cycle({192'h0, 64'hDEAD_BEEF_0000_0001} | {64'h0, 64'h0, 64'h1234_5678_9ABC_DEF0, 64'h0},
               32'h0000_5A01, 4'b0011, 4'b0101);
    lpbk_cycle('0, '0, '0, 4'b0101);
    checks++;
    if (rx_vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL lpbk_early got %b required 0", rx_vld[0]);
    end
    lpbk_cycle('0, '0, '0, 4'b0101);
    checks++;
    if (rx_dat[63:0] !== 64'hDEAD_BEEF_0000_0001 || rx_vld[0] !== 1'b1 || rx_ctl[7:0] !== 8'h01) begin
      errors++;
      $display("FAIL lpbk_lane0 got %h/%b/%h required deadbeef00000001/1/01", rx_dat[63:0], rx_vld[0], rx_ctl[7:0]);
    end
    checks++;
    if (rx_dat[127:64] !== 64'h0 || rx_vld[1] !== 1'b0 || rx_ctl[15:8] !== 8'h0) begin
      errors++;
      $display("FAIL lpbk_lane1_off got %h/%b/%h required 0", rx_dat[127:64], rx_vld[1], rx_ctl[15:8]);
    end
    for (int k = 0; k < 60; k++) begin
      lpbk_cycle(rand_dat(), $urandom(), NL'($urandom()), NL'($urandom()));
      checks++;
      if (init_done !== 1'b1) begin
        errors++;
        $display("FAIL lpbk_ready_held k=%0d got %b required 1", k, init_done);
      end
    end
    tx_dat = '0; tx_ctl = '0; tx_vld = '0; lpbken = '0;
  endtask

  task automatic lpbk_cycle_zero();
    tx_dat = '0; tx_ctl = '0; tx_vld = '0;
    tick();
  endtask

  task automatic test_disruption();
    int n;
    tx_drst[1] = 1'b1;
    tick();
    repeat (2) tick();
    checks++;
    if (tx_rdy !== '0 || rx_rdy !== '0 || init_done !== 1'b0 || lref !== '1 || ldata !== '0) begin
      errors++;
      $display("FAIL drst_status got %h/%h/%b/%h/%h required 0/0/0/f/0", tx_rdy, rx_rdy, init_done, lref, ldata);
    end
    tx_drst[1] = 1'b0;
    wait_init_done(4 * LOCK, n);
    checks++;
    if (n != LOCK + 2) begin
      errors++;
      $display("FAIL drst_recover_len got %0d required %0d", n, LOCK + 2);
    end
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    checks++;
    if (init_done !== 1'b1 || tx_cal_busy !== '0) begin
      errors++;
      $display("FAIL restart_latency got %b/%h required 1/0", init_done, tx_cal_busy);
    end
    tick();
    checks++;
    if (tx_cal_busy !== '1 || rx_cal_busy !== '1 || init_done !== 1'b0 || lref !== '0 || tx_rdy !== '0) begin
      errors++;
      $display("FAIL restart_status got %h/%h/%b/%h/%h required f/f/0/0/0", tx_cal_busy, rx_cal_busy, init_done, lref, tx_rdy);
    end
    wait_init_done(CAL + LOCK + 10, n);
    tx_arst[0] = 1'b1;
    tick();
    tx_arst[0] = 1'b0;
    tick();
    checks++;
    if (tx_cal_busy !== '1 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL ready_arst got %h/%b required f/0", tx_cal_busy, init_done);
    end
    wait_init_done(CAL + LOCK + 10, n);
  endtask

  task automatic test_async_reset();
    int n;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    lpbken = '1;
    for (int k = 0; k < CAL + 6; k++) begin
      tx_dat = rand_dat(); tx_ctl = $urandom(); tx_vld = '1;
      tick();
    end
    checks++;
    if (lref !== '1 || tx_cal_busy !== '0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_lock got %h/%h/%b required f/0/0", lref, tx_cal_busy, init_done);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_cal_busy, rx_cal_busy, lref, ldata, tx_rdy, rx_rdy, init_done} !== '0
        || rx_dat !== '0 || rx_ctl !== '0 || rx_vld !== '0) begin
      errors++;
      $display("FAIL async_reset got %h/%b/%h required 0", lref, init_done, rx_dat);
    end
    tx_dat = '0; tx_ctl = '0; tx_vld = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    wait_init_done(CAL + LOCK + 10, n);
    checks++;
    if (n != CAL + LOCK + 2) begin
      errors++;
      $display("FAIL post_reset_init_len got %0d required %0d", n, CAL + LOCK + 2);
    end
    model_clear();
    for (int k = 0; k < 4; k++) lpbk_cycle('0, '0, '0, '1);
  endtask

  initial begin
    test_reset();
    test_init();
    test_analog_hold();
    test_loopback();
    test_disruption();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule
